// File: rtl/pc_gen_if.sv
// rtl/pc_gen_if.sv - fetch PC generator control and status bundle
interface pc_gen_if #(
  parameter int unsigned XLEN = 32
);
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            call;
  logic            ret;
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic            misalign;
  logic            ras_empty;
  logic            ras_full;

  modport master (
    output stall, redirect_valid, redirect_target, call, ret,
    input  pc, pc_valid, misalign, ras_empty, ras_full
  );

  modport slave (
    input  stall, redirect_valid, redirect_target, call, ret,
    output pc, pc_valid, misalign, ras_empty, ras_full
  );
endinterface

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage program counter with redirects and return-address stack
// The return-address stack is built only when PC_RAS_EN is defined.
module pc_gen #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int unsigned     INC       = 4,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input logic     clk,
  input logic     rst,
  pc_gen_if.slave bus
);
  localparam logic [XLEN-1:0] INC_W = XLEN'(INC);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] pc_inc;
  logic            valid_q;
  logic            misalign_q;
  logic            ras_has;
  logic [XLEN-1:0] ras_top;
  logic            push;
  logic            pop;
  logic            replace;

  assign pc_inc       = pc_q + INC_W;
  assign bus.pc       = pc_q;
  assign bus.pc_valid = valid_q;
  assign bus.misalign = misalign_q;

  // The first edge out of reset only raises pc_valid; fetch starts from RESET_VEC.
  always_comb begin
    pc_next = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    replace = 1'b0;
    if (!valid_q) begin
      pc_next = pc_q;
    end else if (bus.ret && ras_has) begin
      pc_next = ras_top;
      replace = bus.call;
      pop     = !bus.call;
    end else if (bus.ret) begin
      pc_next = bus.redirect_valid ? bus.redirect_target : pc_inc;
      push    = bus.call;
    end else if (bus.redirect_valid) begin
      pc_next = bus.redirect_target;
      push    = bus.call;
    end else if (!bus.stall) begin
      pc_next = pc_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_VEC;
      valid_q    <= 1'b0;
      misalign_q <= (RESET_VEC[1:0] != 2'b00);
    end else begin
      pc_q       <= pc_next;
      valid_q    <= 1'b1;
      misalign_q <= (pc_next[1:0] != 2'b00);
    end
  end

`ifdef PC_RAS_EN
  localparam int unsigned     PTR_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned     CNT_W   = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [PTR_W-1:0] ras_top_idx;
  logic [CNT_W-1:0] ras_cnt;

  // ras_ptr is the next free slot; when full it lands on the oldest entry.
  assign ras_top_idx   = ras_ptr - PTR_W'(1);
  assign ras_top       = ras_mem[ras_top_idx];
  assign ras_has       = (ras_cnt != '0);
  assign bus.ras_empty = (ras_cnt == '0);
  assign bus.ras_full  = (ras_cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (push) begin
      ras_ptr <= ras_ptr + PTR_W'(1);
      if (ras_cnt != CNT_MAX) begin
        ras_cnt <= ras_cnt + CNT_W'(1);
      end
    end else if (pop) begin
      ras_ptr <= ras_ptr - PTR_W'(1);
      ras_cnt <= ras_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ras_mem[ras_ptr] <= pc_inc;
    end else if (replace) begin
      ras_mem[ras_top_idx] <= pc_inc;
    end
  end
`else
  logic ras_unused;

  assign ras_has       = 1'b0;
  assign ras_top       = '0;
  assign bus.ras_empty = 1'b1;
  assign bus.ras_full  = 1'b0;
  assign ras_unused    = ^{push, pop, replace};
`endif
endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen
module tb_pc_gen;
`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pc_gen_if #(.XLEN(32)) bus ();

  pc_gen #(
    .XLEN      (32),
    .RESET_VEC (32'h0000_0100),
    .INC       (4),
    .RAS_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'h0;
    bus.call            = 1'b0;
    bus.ret             = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) tick();
    checks++;
    if (bus.pc !== 32'h100) begin failures++; $display("FAIL reset_pc actual=%h required=%h", bus.pc, 32'h100); end
    checks++;
    if (bus.pc_valid !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%b required=0", bus.pc_valid); end
    checks++;
    if (bus.misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign actual=%b required=0", bus.misalign); end
    checks++;
    if (bus.ras_empty !== 1'b1) begin failures++; $display("FAIL reset_ras_empty actual=%b required=1", bus.ras_empty); end
    checks++;
    if (bus.ras_full !== 1'b0) begin failures++; $display("FAIL reset_ras_full actual=%b required=0", bus.ras_full); end
  endtask

  task automatic test_increment();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h100;
    exp_pc[1] = 32'h104;
    exp_pc[2] = 32'h108;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.pc !== exp_pc[i]) begin failures++; $display("FAIL inc_pc%0d actual=%h required=%h", i, bus.pc, exp_pc[i]); end
      checks++;
      if (bus.pc_valid !== 1'b1) begin failures++; $display("FAIL inc_valid%0d actual=%b required=1", i, bus.pc_valid); end
    end
  endtask

  task automatic test_stall_redirect();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.pc !== 32'h108) begin failures++; $display("FAIL stall_hold%0d actual=%h required=%h", i, bus.pc, 32'h108); end
    end
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h200;
    tick();
    checks++;
    if (bus.pc !== 32'h200) begin failures++; $display("FAIL stall_redirect actual=%h required=%h", bus.pc, 32'h200); end
    clear_inputs();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h10C;
    tick();
    clear_inputs();
    checks++;
    if (bus.pc !== 32'h10C) begin failures++; $display("FAIL redirect_10c actual=%h required=%h", bus.pc, 32'h10C); end
  endtask

  task automatic test_call_return();
    logic [31:0] exp;
    bus.call            = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h400;
    tick();
    clear_inputs();
    checks++;
    if (bus.pc !== 32'h400) begin failures++; $display("FAIL call_pc actual=%h required=%h", bus.pc, 32'h400); end
    checks++;
    if (bus.ras_empty !== !RAS_ON) begin failures++; $display("FAIL call_ras_empty actual=%b required=%b", bus.ras_empty, !RAS_ON); end
    tick();
    bus.ret = 1'b1;
    tick();
    clear_inputs();
    exp = RAS_ON ? 32'h110 : 32'h408;
    checks++;
    if (bus.pc !== exp) begin failures++; $display("FAIL ret_pc actual=%h required=%h", bus.pc, exp); end
    checks++;
    if (bus.ras_empty !== 1'b1) begin failures++; $display("FAIL ret_ras_empty actual=%b required=1", bus.ras_empty); end
    // A bare call with no redirect or return is ignored.
    bus.call = 1'b1;
    tick();
    clear_inputs();
    exp = RAS_ON ? 32'h114 : 32'h40C;
    checks++;
    if (bus.pc !== exp) begin failures++; $display("FAIL bare_call_pc actual=%h required=%h", bus.pc, exp); end
    checks++;
    if (bus.ras_empty !== 1'b1) begin failures++; $display("FAIL bare_call_empty actual=%b required=1", bus.ras_empty); end
    bus.call            = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h500;
    tick();
    clear_inputs();
    tick();
    bus.call = 1'b1;
    bus.ret  = 1'b1;
    tick();
    clear_inputs();
    exp = RAS_ON ? 32'h118 : 32'h508;
    checks++;
    if (bus.pc !== exp) begin failures++; $display("FAIL call_ret_pc actual=%h required=%h", bus.pc, exp); end
    bus.ret             = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h700;
    tick();
    clear_inputs();
    exp = RAS_ON ? 32'h508 : 32'h700;
    checks++;
    if (bus.pc !== exp) begin failures++; $display("FAIL ret_over_redirect actual=%h required=%h", bus.pc, exp); end
    checks++;
    if (bus.ras_empty !== 1'b1) begin failures++; $display("FAIL ret_over_redirect_empty actual=%b required=1", bus.ras_empty); end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] tgt;
    logic [31:0] exp;
    logic        exp_flag;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h1000;
    tick();
    for (int i = 0; i < 5; i++) begin
      tgt = 32'((i + 2) << 12);
      bus.call            = 1'b1;
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = tgt;
      tick();
      checks++;
      if (bus.pc !== tgt) begin failures++; $display("FAIL ovf_call_pc%0d actual=%h required=%h", i, bus.pc, tgt); end
      exp_flag = RAS_ON && (i >= 3);
      checks++;
      if (bus.ras_full !== exp_flag) begin failures++; $display("FAIL ovf_full%0d actual=%b required=%b", i, bus.ras_full, exp_flag); end
    end
    clear_inputs();
    for (int i = 0; i < 5; i++) begin
      bus.ret = 1'b1;
      tick();
      if (RAS_ON) exp = (i < 4) ? 32'(((5 - i) << 12) + 4) : 32'h2008;
      else        exp = 32'h6000 + 32'(4 * (i + 1));
      checks++;
      if (bus.pc !== exp) begin failures++; $display("FAIL ovf_ret_pc%0d actual=%h required=%h", i, bus.pc, exp); end
      exp_flag = RAS_ON ? (i >= 3) : 1'b1;
      checks++;
      if (bus.ras_empty !== exp_flag) begin failures++; $display("FAIL ovf_ret_empty%0d actual=%b required=%b", i, bus.ras_empty, exp_flag); end
    end
    clear_inputs();
  endtask

  task automatic test_wrap_misalign();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFC;
    tick();
    clear_inputs();
    checks++;
    if (bus.pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_top actual=%h required=%h", bus.pc, 32'hFFFF_FFFC); end
    tick();
    checks++;
    if (bus.pc !== 32'h0) begin failures++; $display("FAIL wrap_zero actual=%h required=0", bus.pc); end
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h202;
    tick();
    clear_inputs();
    checks++;
    if (bus.misalign !== 1'b1) begin failures++; $display("FAIL misalign_set actual=%b required=1", bus.misalign); end
    tick();
    checks++;
    if (bus.pc !== 32'h206) begin failures++; $display("FAIL misalign_adv actual=%h required=%h", bus.pc, 32'h206); end
    checks++;
    if (bus.misalign !== 1'b1) begin failures++; $display("FAIL misalign_hold actual=%b required=1", bus.misalign); end
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h300;
    tick();
    clear_inputs();
    checks++;
    if (bus.misalign !== 1'b0) begin failures++; $display("FAIL misalign_clr actual=%b required=0", bus.misalign); end
  endtask

  task automatic test_async_reset();
    bus.call            = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h800;
    tick();
    bus.redirect_target = 32'h900;
    tick();
    clear_inputs();
    checks++;
    if (bus.ras_empty !== !RAS_ON) begin failures++; $display("FAIL pre_rst_empty actual=%b required=%b", bus.ras_empty, !RAS_ON); end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.pc !== 32'h100) begin failures++; $display("FAIL arst_pc actual=%h required=%h", bus.pc, 32'h100); end
    checks++;
    if (bus.pc_valid !== 1'b0) begin failures++; $display("FAIL arst_valid actual=%b required=0", bus.pc_valid); end
    checks++;
    if (bus.ras_empty !== 1'b1) begin failures++; $display("FAIL arst_empty actual=%b required=1", bus.ras_empty); end
    checks++;
    if (bus.ras_full !== 1'b0) begin failures++; $display("FAIL arst_full actual=%b required=0", bus.ras_full); end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.pc !== 32'h100 || bus.pc_valid !== 1'b1) begin failures++; $display("FAIL arst_release actual=%h/%b required=%h/1", bus.pc, bus.pc_valid, 32'h100); end
    bus.ret = 1'b1;
    tick();
    clear_inputs();
    checks++;
    if (bus.pc !== 32'h104) begin failures++; $display("FAIL arst_ret_empty actual=%h required=%h", bus.pc, 32'h104); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    clear_inputs();
    test_reset();
    test_increment();
    test_stall_redirect();
    test_call_return();
    test_ras_overflow();
    test_wrap_misalign();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
